seg7_scan_driver: RTL

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It sits directly downstream of the AES encrypt core and consumes that core's 32-bit `HEX` word and display-enable (`lcd_mode`) output. Each nibble is shown as one hex digit. The word is double-buffered so a new value only reaches the display at a frame boundary, which prevents tearing. The decimal point of digit 0 flashes for a few frames after each update.

---
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver.
// The hex word is double-buffered and reaches the display only at a frame boundary.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned UPD_FRAMES  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] HEX_IN,
    input  logic        HEX_VALID,
    input  logic        DISP_EN,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int unsigned DivW = $clog2(REFRESH_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(REFRESH_DIV - 1);
    localparam logic [7:0] UpdInit = 8'(UPD_FRAMES);

    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      dig_q, dig_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     pend_q, pend_d;
    logic            pflag_q, pflag_d;
    logic [7:0]      upd_q, upd_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic       tick;
    logic       frm;
    logic       load;
    logic [3:0] nib;
    logic [6:0] seg_dec;

    always_comb begin
        tick = (div_q == DivMax);
        frm  = tick && (dig_q == 3'd7);

        div_d = tick ? '0 : div_q + 1'b1;
        dig_d = tick ? dig_q + 3'd1 : dig_q;

        pend_d   = HEX_VALID ? HEX_IN : pend_q;
        pflag_d  = pflag_q | HEX_VALID;
        shadow_d = shadow_q;
        load     = 1'b0;
        if (frm) begin
            // A strobe in the frame-boundary cycle bypasses the pending buffer.
            if (HEX_VALID) begin
                shadow_d = HEX_IN;
                load     = 1'b1;
            end else if (pflag_q) begin
                shadow_d = pend_q;
                load     = 1'b1;
            end
            pflag_d = 1'b0;
        end

        upd_d = upd_q;
        if (load) begin
            upd_d = UpdInit;
        end else if (frm && (upd_q != 8'd0)) begin
            upd_d = upd_q - 8'd1;
        end
    end

    always_comb begin
        nib = shadow_q[{dig_q, 2'b00} +: 4];
        unique case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase

        if (DISP_EN) begin
            an_d  = ~(8'd1 << dig_q);
            seg_d = seg_dec;
            dp_d  = !((dig_q == 3'd0) && (upd_q != 8'd0));
        end else begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q    <= '0;
            dig_q    <= 3'd0;
            shadow_q <= 32'd0;
            pend_q   <= 32'd0;
            pflag_q  <= 1'b0;
            upd_q    <= 8'd0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            div_q    <= div_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            upd_q    <= upd_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule
